scarv_mem_axi_arbiter: RTL

- Parametrised successor to the single-master SRAM-to-AXI4-lite adapter used for the COP memory port.
- Accepts PORTS enable/stall style memory requestors (CPU data, COP, future DMA) and serialises them onto one AXI4-lite master with round-robin arbitration.
- Unlike the previous adapter, reports bus errors from BRESP/RRESP back to the requesting port.

---
 rtl/scarv_mem_axi_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/scarv_mem_axi_arbiter.sv
// Round-robin arbiter that serialises PORTS enable/stall memory requestors onto a
// single AXI4-lite master, one transaction at a time, returning bus errors per port.
module scarv_mem_axi_arbiter #(
    parameter int         PORTS    = 2,
    parameter int         AW       = 32,
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    input  logic [PORTS-1:0]    req_cen,
    input  logic [PORTS-1:0]    req_wen,
    input  logic [PORTS*AW-1:0] req_addr,
    input  logic [PORTS*32-1:0] req_wdata,
    input  logic [PORTS*4-1:0]  req_ben,
    output logic [31:0]         req_rdata,
    output logic [PORTS-1:0]    req_stall,
    output logic [PORTS-1:0]    req_error,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [AW-1:0]       axi_awaddr,
    output logic [2:0]          axi_awprot,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    output logic [31:0]         axi_wdata,
    output logic [3:0]          axi_wstrb,
    input  logic                axi_bvalid,
    output logic                axi_bready,
    input  logic [1:0]          axi_bresp,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    output logic [AW-1:0]       axi_araddr,
    output logic [2:0]          axi_arprot,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    input  logic [31:0]         axi_rdata,
    input  logic [1:0]          axi_rresp
);

    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   rr, grant, pick, rr_next;
    logic [GW:0]     idx;
    logic            found;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata, rdata;
    logic [3:0]      ben;
    logic            error, aw_done, w_done, aw_hs, w_hs;

    // Search for the first requesting port starting at the round-robin pointer.
    always_comb begin
        pick  = rr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < PORTS; k++) begin
            idx = {1'b0, rr} + (GW+1)'(k);
            if (idx >= (GW+1)'(PORTS)) idx = idx - (GW+1)'(PORTS);
            if (!found && req_cen[idx[GW-1:0]]) begin
                pick  = idx[GW-1:0];
                found = 1'b1;
            end
        end
    end

    assign rr_next = (grant == GW'(PORTS-1)) ? '0 : grant + 1'b1;

    assign axi_awvalid = (state == WR_ADDR) && !aw_done;
    assign axi_wvalid  = (state == WR_ADDR) && !w_done;
    assign axi_bready  = (state == WR_RESP);
    assign axi_arvalid = (state == RD_ADDR);
    assign axi_rready  = (state == RD_RESP);
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;

    assign axi_awaddr  = addr & {{(AW-2){1'b1}}, 2'b00};
    assign axi_araddr  = addr & {{(AW-2){1'b1}}, 2'b00};
    assign axi_awprot  = AXI_PROT;
    assign axi_arprot  = AXI_PROT;
    assign axi_wdata   = wdata;
    assign axi_wstrb   = ben;
    assign req_rdata   = rdata;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = req_wen[pick] ? WR_ADDR : RD_ADDR;
            WR_ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
            WR_RESP: if (axi_bvalid) state_n = DONE;
            RD_ADDR: if (axi_arready) state_n = RD_RESP;
            RD_RESP: if (axi_rvalid) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= IDLE;
        else           state <= state_n;
    end

    // The AW and W channels may complete in different cycles, so each is tracked separately.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rr      <= '0;
            grant   <= '0;
            addr    <= '0;
            wdata   <= '0;
            ben     <= '0;
            rdata   <= '0;
            error   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant   <= pick;
                    addr    <= req_addr[pick*AW +: AW];
                    wdata   <= req_wdata[pick*32 +: 32];
                    ben     <= req_ben[pick*4 +: 4];
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                WR_ADDR: begin
                    aw_done <= aw_done || aw_hs;
                    w_done  <= w_done || w_hs;
                end
                WR_RESP: if (axi_bvalid) error <= (axi_bresp != 2'b00);
                RD_RESP: if (axi_rvalid) begin
                    rdata <= axi_rdata;
                    error <= (axi_rresp != 2'b00);
                end
                DONE:    rr <= rr_next;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_stall = '0;
        req_error = '0;
        for (int i = 0; i < PORTS; i++) begin
            req_stall[i] = req_cen[i] && !((state == DONE) && (grant == GW'(i)));
            req_error[i] = (state == DONE) && (grant == GW'(i)) && error;
        end
    end

endmodule
